// File: rtl/mnist_frame_buffer.sv
// mnist_frame_buffer: ping-pong pixel store between the camera capture path and
// the classifier. The writer fills wr_bank while the reader consumes a complete,
// stable frame from the other bank. A completed frame is swapped in only when the
// read bank is free; otherwise it is dropped and counted.
// Optional build macro: MNIST_FB_STATS_EN (per-frame nonzero-pixel statistics).
module mnist_frame_buffer #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned RD_LAT = 1,
  localparam int unsigned DEPTH  = IMG_W * IMG_H,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_end,
  output logic              frame_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_release,
  output logic [7:0]        frame_id,
  output logic [15:0]       drop_cnt,
  output logic [ADDR_W:0]   pix_count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  // Frame-level control state
  logic        wr_bank_q, wr_bank_d;
  logic        full_q, full_d;
  logic [7:0]  frame_id_q, frame_id_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic wr_in_range, rd_in_range;
  logic rel, swap, drop, wr_fire, rd_acc, rd_bank;

  // Storage: two banks, no reset on contents
  logic [DATA_W-1:0] bank0_mem [DEPTH];
  logic [DATA_W-1:0] bank1_mem [DEPTH];

  // Read pipeline stage 1 (RAM output)
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;

  // Frame-end resolution: release is applied first, so a same-cycle release
  // and frame end always swaps and full never drops low.
  always_comb begin
    wr_in_range = {1'b0, wr_addr} < DEPTH_C;
    rd_in_range = {1'b0, rd_addr} < DEPTH_C;
    wr_fire     = wr_en & wr_in_range & ~rst;
    rd_acc      = rd_en & full_q;
    rd_bank     = ~wr_bank_q;
    rel         = rd_release & full_q;
    swap        = wr_frame_end & (~full_q | rel);
    drop        = wr_frame_end & ~swap;
    wr_bank_d   = wr_bank_q;
    full_d      = full_q & ~rel;
    frame_id_d  = frame_id_q;
    drop_cnt_d  = drop_cnt_q;
    if (swap) begin
      wr_bank_d  = ~wr_bank_q;
      full_d     = 1'b1;
      frame_id_d = frame_id_q + 8'd1;
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      full_q     <= 1'b0;
      frame_id_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      frame_id_q <= frame_id_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Pixel writes into the current write bank
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_bank_q) bank1_mem[wr_addr] <= wr_data;
      else           bank0_mem[wr_addr] <= wr_data;
    end
  end

  // Read stage 1: bank and address are fixed at acceptance; holds when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) begin
        if (!rd_in_range) s1_data_q <= '0;
        else if (rd_bank) s1_data_q <= bank1_mem[rd_addr];
        else              s1_data_q <= bank0_mem[rd_addr];
      end
    end
  end

  generate
    if (RD_LAT >= 2) begin : g_rd_lat2
      logic              s2_valid_q;
      logic [DATA_W-1:0] s2_data_q;

      // Read stage 2: output register, updated only by valid stage-1 data
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) s2_data_q <= s1_data_q;
        end
      end

      assign rd_valid = s2_valid_q;
      assign rd_data  = s2_data_q;
    end else begin : g_rd_lat1
      assign rd_valid = s1_valid_q;
      assign rd_data  = s1_data_q;
    end
  endgenerate

  assign frame_ready = full_q;
  assign frame_id    = frame_id_q;
  assign drop_cnt    = drop_cnt_q;

`ifdef MNIST_FB_STATS_EN
  logic [ADDR_W:0] nz_cnt_q, nz_cnt_d;
  logic [ADDR_W:0] pix_count_q, pix_count_d;

  // Per-frame nonzero counter; the swap latches the count including a
  // same-cycle write, then the counter restarts for the next frame.
  always_comb begin
    nz_cnt_d    = nz_cnt_q;
    pix_count_d = pix_count_q;
    if (wr_fire && (wr_data != '0) && (nz_cnt_q != '1)) begin
      nz_cnt_d = nz_cnt_q + (ADDR_W + 1)'(1);
    end
    if (swap) begin
      pix_count_d = nz_cnt_d;
      nz_cnt_d    = '0;
    end else if (drop) begin
      nz_cnt_d = '0;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      nz_cnt_q    <= '0;
      pix_count_q <= '0;
    end else begin
      nz_cnt_q    <= nz_cnt_d;
      pix_count_q <= pix_count_d;
    end
  end

  assign pix_count = pix_count_q;
`else
  assign pix_count = '0;
`endif

endmodule

// File: tb/tb_mnist_frame_buffer.sv
// Directed testbench for mnist_frame_buffer (28x28, 8-bit pixels, RD_LAT=2).
module tb_mnist_frame_buffer;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = IMG_W * IMG_H;   // 784
  localparam int AW     = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_end;
  logic              frame_ready;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_release;
  logic [7:0]        frame_id;
  logic [15:0]       drop_cnt;
  logic [AW:0]       pix_count;

  int unsigned vecs = 0;
  int unsigned errs = 0;
  logic [7:0]  model [DEPTH];
  logic [7:0]  last_rd;

  always #5 clk = ~clk;

  mnist_frame_buffer #(
    .DATA_W(DATA_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_frame_end(wr_frame_end),
    .frame_ready (frame_ready),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_release  (rd_release),
    .frame_id    (frame_id),
    .drop_cnt    (drop_cnt),
    .pix_count   (pix_count)
  );

  function automatic logic [7:0] pix(input int kind, input int a);
    logic [31:0] av;
    av = a;
    case (kind)
      0:       pix = {7'b0, av[0]};
      1:       pix = 8'h00;
      2:       pix = av[7:0] ^ 8'h5A;
      3:       pix = 8'(a * 3 + 1);
      4:       pix = 8'(255 - a);
      default: pix = (a >= DEPTH - 100) ? 8'(a - (DEPTH - 101)) : 8'h00;
    endcase
  endfunction

  function automatic logic [AW:0] exp_pix(input int kind);
    int n;
    n = 0;
`ifdef MNIST_FB_STATS_EN
    for (int a = 0; a < DEPTH; a++) if (pix(kind, a) != 8'h00) n++;
`endif
    exp_pix = (AW + 1)'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_frame_end = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
  endtask

  task automatic load_model(input int kind);
    for (int a = 0; a < DEPTH; a++) model[a] = pix(kind, a);
  endtask

  // One stray out-of-range write, then a full frame; frame end (and optionally
  // release) coincides with the last pixel write.
  task automatic write_frame(input int kind, input bit rel_at_end);
    wr_en = 1'b1; wr_addr = AW'(1000); wr_data = 8'hEE;
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = pix(kind, a);
      wr_frame_end = (a == DEPTH - 1);
      rd_release = rel_at_end && (a == DEPTH - 1);
      tick();
    end
    idle_inputs();
  endtask

  task automatic read_sweep(input string name);
    int idx;
    bit ev;
    for (int c = 0; c <= DEPTH + RD_LAT - 2; c++) begin
      rd_en = (c < DEPTH); rd_addr = AW'(c);
      tick();
      idx = c - RD_LAT + 1;
      ev = (idx >= 0) && (idx < DEPTH);
      vecs++;
      if (rd_valid !== ev) begin
        errs++;
        $display("FAIL %s_valid c=%0d: got %b expected %b", name, c, rd_valid, ev);
      end
      if (ev) begin
        vecs++;
        if (rd_data !== model[idx]) begin
          errs++;
          $display("FAIL %s_data addr=%0d: got %h expected %h", name, idx, rd_data, model[idx]);
        end
        last_rd = model[idx];
      end
    end
    idle_inputs();
  endtask

  task automatic check_status(input string name, input logic rdy, input logic [7:0] fid,
                              input logic [15:0] dc, input logic [AW:0] pc);
    vecs++;
    if (frame_ready !== rdy) begin
      errs++; $display("FAIL %s_ready: got %b expected %b", name, frame_ready, rdy);
    end
    vecs++;
    if (frame_id !== fid) begin
      errs++; $display("FAIL %s_frame_id: got %0d expected %0d", name, frame_id, fid);
    end
    vecs++;
    if (drop_cnt !== dc) begin
      errs++; $display("FAIL %s_drop_cnt: got %0d expected %0d", name, drop_cnt, dc);
    end
    vecs++;
    if (pix_count !== pc) begin
      errs++; $display("FAIL %s_pix_count: got %0d expected %0d", name, pix_count, pc);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_status("reset", 1'b0, 8'd0, 16'd0, '0);
    vecs++;
    if (rd_valid !== 1'b0) begin
      errs++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid);
    end
    vecs++;
    if (rd_data !== 8'h00) begin
      errs++; $display("FAIL reset_rd_data: got %h expected 00", rd_data);
    end
  endtask

  task automatic test_fill_read();
    write_frame(0, 1'b0);
    check_status("fill", 1'b1, 8'd1, 16'd0, exp_pix(0));
    load_model(0);
    read_sweep("fill_rd");
  endtask

  task automatic test_drop();
    write_frame(1, 1'b0);
    write_frame(2, 1'b0);
    check_status("drop", 1'b1, 8'd1, 16'd2, exp_pix(0));
    read_sweep("drop_rd");
    rd_release = 1'b1;
    tick();
    idle_inputs();
    check_status("release", 1'b0, 8'd1, 16'd2, exp_pix(0));
    write_frame(3, 1'b0);
    check_status("after_rel", 1'b1, 8'd2, 16'd2, exp_pix(3));
    load_model(3);
    read_sweep("f4_rd");
  endtask

  task automatic test_release_swap();
    write_frame(4, 1'b1);
    check_status("relswap", 1'b1, 8'd3, 16'd2, exp_pix(4));
    tick();
    check_status("relswap_hold", 1'b1, 8'd3, 16'd2, exp_pix(4));
    load_model(4);
    read_sweep("relswap_rd");
  endtask

  task automatic test_read_gating();
    rd_release = 1'b1;
    tick();
    idle_inputs();
    check_status("gate_rel", 1'b0, 8'd3, 16'd2, exp_pix(4));
    for (int i = 0; i < RD_LAT + 2; i++) begin
      rd_en = 1'b1; rd_addr = AW'(5);
      tick();
      vecs++;
      if (rd_valid !== 1'b0 || rd_data !== last_rd) begin
        errs++;
        $display("FAIL gate_noread i=%0d: got valid=%b data=%h expected valid=0 data=%h",
                 i, rd_valid, rd_data, last_rd);
      end
    end
    idle_inputs();
    write_frame(0, 1'b0);
    check_status("gate_swap", 1'b1, 8'd4, 16'd2, exp_pix(0));
    for (int k = 0; k < 2; k++) begin
      for (int t = 1; t <= RD_LAT; t++) begin
        rd_en = (t == 1); rd_addr = (k == 0) ? AW'(DEPTH) : AW'(1023);
        tick();
        vecs++;
        if (t < RD_LAT) begin
          if (rd_valid !== 1'b0) begin
            errs++; $display("FAIL oob_early k=%0d t=%0d: got valid=%b expected 0", k, t, rd_valid);
          end
        end else if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
          errs++;
          $display("FAIL oob_read k=%0d: got valid=%b data=%h expected valid=1 data=00",
                   k, rd_valid, rd_data);
        end
      end
    end
    idle_inputs();
    tick();
    vecs++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      errs++; $display("FAIL oob_hold: got valid=%b data=%h expected valid=0 data=00", rd_valid, rd_data);
    end
  endtask

  task automatic test_reset_midframe();
    rd_release = 1'b1;
    tick();
    idle_inputs();
    for (int a = 0; a < 500; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = pix(3, a);
      tick();
    end
    wr_en = 1'b1; wr_addr = AW'(500); wr_data = pix(3, 500); rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    check_status("midrst", 1'b0, 8'd0, 16'd0, '0);
    vecs++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      errs++; $display("FAIL midrst_rd: got valid=%b data=%h expected valid=0 data=00", rd_valid, rd_data);
    end
    write_frame(2, 1'b0);
    check_status("midrst_swap", 1'b1, 8'd1, 16'd0, exp_pix(2));
    load_model(2);
    read_sweep("midrst_rd");
  endtask

  task automatic test_stats();
    rd_release = 1'b1;
    tick();
    idle_inputs();
    write_frame(5, 1'b0);
    check_status("stats_swap", 1'b1, 8'd2, 16'd0, exp_pix(5));
    write_frame(0, 1'b0);
    check_status("stats_drop", 1'b1, 8'd2, 16'd1, exp_pix(5));
    load_model(5);
    read_sweep("stats_rd");
  endtask

  initial begin
    rst = 1'b1;
    last_rd = 8'h00;
    idle_inputs();
    test_reset();
    test_fill_read();
    test_drop();
    test_release_swap();
    test_read_gating();
    test_reset_midframe();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
